// File: rtl/req_fifo_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : req_fifo_arb_if
// Brief    : Bundles the upstream FIFO head/pop signals and the downstream
//            valid/ready request port of the round-robin drain stage.
//            The master modport is the arbiter side; the slave modport is
//            the FIFO bank plus consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface req_fifo_arb_if #(
    parameter int NUM_FIFO   = 4,
    parameter int DATA_WIDTH = 6
);
    localparam int c_SRC_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

    logic [NUM_FIFO-1:0]            fifo_empty;
    logic [NUM_FIFO*DATA_WIDTH-1:0] fifo_dout;
    logic [NUM_FIFO-1:0]            fifo_ren;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          out_data;
    logic [c_SRC_W-1:0]             out_src;
    logic [15:0]                    grant_cnt;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_ren, out_valid, out_data, out_src, grant_cnt
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_ren, out_valid, out_data, out_src, grant_cnt
    );
endinterface
`default_nettype wire

// File: rtl/req_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : req_fifo_arb
// Brief    : Round-robin drain of NUM_FIFO request FIFOs into a single
//            registered valid/ready output. One pop per cycle while the
//            output register is free or being emptied.
// Revision : 1.0 - initial release
// ============================================================================
module req_fifo_arb #(
    parameter int NUM_FIFO   = 4,
    parameter int DATA_WIDTH = 6
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    req_fifo_arb_if.master  bus
);
    localparam int c_SRC_W = (NUM_FIFO > 1) ? $clog2(NUM_FIFO) : 1;

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [c_SRC_W-1:0]    r_src;
    logic [c_SRC_W-1:0]    r_last;
    logic [15:0]           r_grant_cnt;

    logic                  w_load;
    logic                  w_any_req;
    logic                  w_pop;
    logic [c_SRC_W-1:0]    w_sel;
    logic [DATA_WIDTH-1:0] w_head;

    // Register is usable when empty or being drained this cycle; pops are
    // suppressed during reset so the upstream FIFOs never see a stray Ren.
    always_comb begin
        w_load    = ~r_valid | bus.out_ready;
        w_any_req = ~&bus.fifo_empty;
        w_pop     = w_load & w_any_req & rst_n;
    end

    // Rotating priority: first non-empty FIFO after the last winner.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        w_sel = r_last;
        for (int k = 1; k <= NUM_FIFO; k++) begin
            idx = (int'(r_last) + k) % NUM_FIFO;
            if (!found && !bus.fifo_empty[idx]) begin
                w_sel = c_SRC_W'(idx);
                found = 1'b1;
            end
        end
    end

    // Head of the winning FIFO and the one-hot pop strobe.
    always_comb begin
        w_head       = bus.fifo_dout[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
        bus.fifo_ren = '0;
        if (w_pop) begin
            bus.fifo_ren[w_sel] = 1'b1;
        end
    end

    // Output register, round-robin pointer and saturating grant counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_src       <= '0;
            r_last      <= c_SRC_W'(NUM_FIFO - 1);
            r_grant_cnt <= '0;
        end else if (w_load) begin
            if (w_any_req) begin
                r_valid <= 1'b1;
                r_data  <= w_head;
                r_src   <= w_sel;
                r_last  <= w_sel;
                if (r_grant_cnt != 16'hFFFF) begin
                    r_grant_cnt <= r_grant_cnt + 16'd1;
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_src   = r_src;
    assign bus.grant_cnt = r_grant_cnt;

endmodule
`default_nettype wire

// File: tb/tb_req_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_fifo_arb
// Brief    : Directed-vector bench for req_fifo_arb (NUM_FIFO=4,
//            DATA_WIDTH=6). Inputs change on the falling edge; outputs are
//            compared on the falling edge against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_fifo_arb;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    req_fifo_arb_if #(.NUM_FIFO(4), .DATA_WIDTH(6)) bus ();

    req_fifo_arb #(.NUM_FIFO(4), .DATA_WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_heads(input logic [5:0] h0, input logic [5:0] h1,
                             input logic [5:0] h2, input logic [5:0] h3);
        bus.fifo_dout = {h3, h2, h1, h0};
    endtask

    logic [31:0] exp_ren_rr  [5] = '{'h1, 'h2, 'h4, 'h8, 'h1};
    logic [31:0] exp_data_rr [5] = '{'h0A, 'h0B, 'h0C, 'h0D, 'h0A};
    logic [31:0] exp_ren_sk  [4] = '{'h4, 'h1, 'h4, 'h1};
    logic [31:0] exp_src_sk  [4] = '{'h2, 'h0, 'h2, 'h0};

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.fifo_empty = 4'b1111;
        bus.out_ready  = 1'b1;
        set_heads(6'h0A, 6'h0B, 6'h0C, 6'h0D);

        // Reset state, including pop suppression with requests pending.
        @(negedge clk);
        bus.fifo_empty = 4'b0000;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 'h0);
        chk("rst_ren",   32'(bus.fifo_ren),  'h0);
        chk("rst_cnt",   32'(bus.grant_cnt), 'h0);
        chk("rst_data",  32'(bus.out_data),  'h0);
        chk("rst_src",   32'(bus.out_src),   'h0);

        // Full-rate round robin.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rr_ren", 32'(bus.fifo_ren), exp_ren_rr[i]);
            tick();
            #1;
            chk("rr_data", 32'(bus.out_data), exp_data_rr[i]);
        end
        chk("rr_valid", 32'(bus.out_valid), 'h1);
        chk("rr_cnt",   32'(bus.grant_cnt), 'd5);

        // Skip empty FIFOs 1 and 3, last winner is 0.
        bus.fifo_empty = 4'b1010;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("skip_ren", 32'(bus.fifo_ren), exp_ren_sk[i]);
            tick();
            #1;
            chk("skip_src", 32'(bus.out_src), exp_src_sk[i]);
        end
        chk("skip_cnt", 32'(bus.grant_cnt), 'd9);

        // Load 6'h15 from FIFO 1, then hold it under backpressure.
        set_heads(6'h0A, 6'h15, 6'h0C, 6'h0D);
        bus.fifo_empty = 4'b1101;
        #1;
        chk("bp_load_ren", 32'(bus.fifo_ren), 'h2);
        tick();
        bus.fifo_empty = 4'b0000;
        bus.out_ready  = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ren",   32'(bus.fifo_ren),  'h0);
            chk("bp_data",  32'(bus.out_data),  'h15);
            chk("bp_src",   32'(bus.out_src),   'h1);
            chk("bp_valid", 32'(bus.out_valid), 'h1);
            tick();
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_resume_ren", 32'(bus.fifo_ren), 'h4);
        tick();
        #1;
        chk("bp_resume_data", 32'(bus.out_data), 'h0C);
        chk("bp_resume_src",  32'(bus.out_src),  'h2);
        chk("bp_cnt",         32'(bus.grant_cnt), 'd11);

        // Drain to idle: single entry 6'h3F in FIFO 3.
        set_heads(6'h0A, 6'h15, 6'h0C, 6'h3F);
        bus.fifo_empty = 4'b0111;
        #1;
        chk("drain_ren", 32'(bus.fifo_ren), 'h8);
        tick();
        bus.fifo_empty = 4'b1111;
        #1;
        chk("drain_ren_idle", 32'(bus.fifo_ren),  'h0);
        chk("drain_valid",    32'(bus.out_valid), 'h1);
        chk("drain_data",     32'(bus.out_data),  'h3F);
        tick();
        #1;
        chk("idle_valid", 32'(bus.out_valid), 'h0);
        chk("idle_data",  32'(bus.out_data),  'h3F);
        chk("idle_src",   32'(bus.out_src),   'h3);
        chk("idle_cnt",   32'(bus.grant_cnt), 'd12);

        // Counter saturation from 16'hFFFE.
        force dut.r_grant_cnt = 16'hFFFE;
        #1;
        release dut.r_grant_cnt;
        #1;
        chk("sat_preset", 32'(bus.grant_cnt), 'hFFFE);
        bus.fifo_empty = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("sat_cnt", 32'(bus.grant_cnt), 'hFFFF);
        end

        // Reset mid-operation while a request is being held.
        bus.out_ready = 1'b0;
        tick();
        #1;
        chk("mid_hold_valid", 32'(bus.out_valid), 'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 'h0);
        chk("mid_rst_ren",   32'(bus.fifo_ren),  'h0);
        chk("mid_rst_cnt",   32'(bus.grant_cnt), 'h0);
        bus.out_ready = 1'b1;
        tick();
        #1;
        chk("mid_rst_ren2", 32'(bus.fifo_ren), 'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ren", 32'(bus.fifo_ren), 'h1);
        tick();
        #1;
        chk("post_rst_src",  32'(bus.out_src),   'h0);
        chk("post_rst_data", 32'(bus.out_data),  'h0A);
        chk("post_rst_cnt",  32'(bus.grant_cnt), 'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
